instruction_fetch_unit: RTL and testbench

//  Upstream stage of the ALU instruction decoder. Owns the program counter and fetches 16-bit instruction words over a req/ack memory port.

---
 rtl/instruction_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 16-bit words over a req/ack port
// and holds each word on `instruction` until the execute side reports completion.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset, launches the first fetch at pc
// FETCH | mem_req high with stable mem_addr, waiting for mem_ack
// EXEC  | instruction held valid, waiting for exec_done
// ERROR | fetch timed out, sticky until rst
module instruction_fetch_unit #(
   parameter int                    ADDR_WIDTH     = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
   parameter int                    TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_req,
   input  logic                  mem_ack,
   input  logic [15:0]           mem_rdata,
   output logic [15:0]           instruction,
   output logic                  instruction_valid,
   input  logic                  exec_done,
   input  logic                  program_counter_increment,
   input  logic                  pc_load,
   input  logic [ADDR_WIDTH-1:0] pc_load_value,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  fetch_error
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TC_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TC_INT);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      ERROR = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] fetch_cnt;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic             timeout_hit;

   // Jump target wins over the sequential step; the add wraps naturally.
   always_comb begin
      pc_next = pc + {{(ADDR_WIDTH-1){1'b0}}, program_counter_increment};
      if (pc_load)
         pc_next = pc_load_value;
   end

   always_comb begin
      timeout_hit = 1'b0;
      if (TIMEOUT_EN)
         timeout_hit = (fetch_cnt == TC_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         pc                <= RESET_PC;
         mem_addr          <= RESET_PC;
         mem_req           <= 1'b0;
         instruction       <= 16'h0000;
         instruction_valid <= 1'b0;
         fetch_error       <= 1'b0;
         fetch_cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               mem_req   <= 1'b1;
               mem_addr  <= pc;
               fetch_cnt <= '0;
               state     <= FETCH;
            end

            FETCH: begin
               if (mem_ack) begin
                  instruction       <= mem_rdata;
                  instruction_valid <= 1'b1;
                  mem_req           <= 1'b0;
                  fetch_cnt         <= '0;
                  state             <= EXEC;
               end else if (timeout_hit) begin
                  mem_req           <= 1'b0;
                  instruction_valid <= 1'b0;
                  fetch_error       <= 1'b1;
                  fetch_cnt         <= '0;
                  state             <= ERROR;
               end else begin
                  fetch_cnt <= fetch_cnt + 1'b1;
               end
            end

            EXEC: begin
               if (exec_done) begin
                  pc                <= pc_next;
                  mem_addr          <= pc_next;
                  mem_req           <= 1'b1;
                  instruction_valid <= 1'b0;
                  fetch_cnt         <= '0;
                  state             <= FETCH;
               end
            end

            ERROR: begin
               mem_req           <= 1'b0;
               instruction_valid <= 1'b0;
               fetch_error       <= 1'b1;
            end

            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: fetch/exec handshake, PC update,
// wrap, jump priority, timeout to ERROR and reset mid-fetch.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] instruction;
   logic        instruction_valid;
   logic        exec_done;
   logic        program_counter_increment;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic [15:0] pc;
   logic        fetch_error;

   int n_checks = 0;
   int n_errors = 0;

   instruction_fetch_unit #(
      .ADDR_WIDTH    (16),
      .RESET_PC      (16'h0000),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .mem_addr                 (mem_addr),
      .mem_req                  (mem_req),
      .mem_ack                  (mem_ack),
      .mem_rdata                (mem_rdata),
      .instruction              (instruction),
      .instruction_valid        (instruction_valid),
      .exec_done                (exec_done),
      .program_counter_increment(program_counter_increment),
      .pc_load                  (pc_load),
      .pc_load_value            (pc_load_value),
      .pc                       (pc),
      .fetch_error              (fetch_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ack(input logic [15:0] data, input string tag);
      mem_ack   = 1'b1;
      mem_rdata = data;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      chk({tag, "_valid"}, instruction_valid, 1'b1);
      chk({tag, "_instr"}, instruction, data);
      chk({tag, "_req_lo"}, mem_req, 1'b0);
   endtask

   task automatic do_exec(input logic inc, input logic ld, input logic [15:0] val,
                          input logic [15:0] exp_addr, input string tag);
      exec_done                 = 1'b1;
      program_counter_increment = inc;
      pc_load                   = ld;
      pc_load_value             = val;
      tick();
      exec_done                 = 1'b0;
      program_counter_increment = 1'b0;
      pc_load                   = 1'b0;
      pc_load_value             = 16'h0000;
      chk({tag, "_addr"}, mem_addr, exp_addr);
      chk({tag, "_pc"}, pc, exp_addr);
      chk({tag, "_req"}, mem_req, 1'b1);
      chk({tag, "_valid_lo"}, instruction_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = 16'h0000;
      exec_done = 1'b0;
      program_counter_increment = 1'b0;
      pc_load = 1'b0;
      pc_load_value = 16'h0000;
      tick();
      tick();

      chk("rst_pc", pc, 16'h0000);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_instr", instruction, 16'h0000);
      chk("rst_valid", instruction_valid, 1'b0);
      chk("rst_err", fetch_error, 1'b0);

      // Test 1: ack on third FETCH cycle
      rst = 1'b0;
      tick();
      chk("t1_req_c1", mem_req, 1'b1);
      chk("t1_addr", mem_addr, 16'h0000);
      tick();
      chk("t1_req_c2", mem_req, 1'b1);
      tick();
      chk("t1_req_c3", mem_req, 1'b1);
      chk("t1_valid_lo", instruction_valid, 1'b0);
      do_ack(16'h1234, "t1");

      // EXEC holds against idle cycles and a stray ack
      tick();
      chk("hold_pc", pc, 16'h0000);
      chk("hold_valid", instruction_valid, 1'b1);
      mem_ack = 1'b1;
      mem_rdata = 16'hBEEF;
      tick();
      mem_ack = 1'b0;
      mem_rdata = 16'h0000;
      chk("stray_ack_instr", instruction, 16'h1234);
      chk("stray_ack_req", mem_req, 1'b0);

      // Test 2: sequential advance
      do_exec(1'b1, 1'b0, 16'h0000, 16'h0001, "t2a");
      do_ack(16'hA001, "t2a");
      do_exec(1'b1, 1'b0, 16'h0000, 16'h0002, "t2b");
      // exec_done during FETCH must not move the PC
      exec_done = 1'b1;
      program_counter_increment = 1'b1;
      tick();
      exec_done = 1'b0;
      program_counter_increment = 1'b0;
      chk("t2_fetch_ign_pc", pc, 16'h0002);
      chk("t2_fetch_ign_addr", mem_addr, 16'h0002);
      do_ack(16'hA002, "t2b");
      do_exec(1'b1, 1'b0, 16'h0000, 16'h0003, "t2c");
      do_ack(16'hA003, "t2c");

      // Test 3: jump beats increment at pc=0005
      do_exec(1'b1, 1'b0, 16'h0000, 16'h0004, "t3a");
      do_ack(16'h0004, "t3a");
      do_exec(1'b1, 1'b0, 16'h0000, 16'h0005, "t3b");
      do_ack(16'h0005, "t3b");
      do_exec(1'b1, 1'b1, 16'h0040, 16'h0040, "t3_jump");
      do_ack(16'h0040, "t3_jump");

      // Test 4: wrap and self-loop
      do_exec(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, "t4_ld");
      do_ack(16'hFFFF, "t4_ld");
      do_exec(1'b1, 1'b0, 16'h0000, 16'h0000, "t4_wrap");
      do_ack(16'h0000, "t4_wrap");
      do_exec(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, "t4_ld2");
      do_ack(16'h5555, "t4_ld2");
      do_exec(1'b0, 1'b0, 16'h0000, 16'hFFFF, "t4_spin");
      do_ack(16'h6666, "t4_spin");

      // Test 6: reset mid-FETCH at 0010
      do_exec(1'b0, 1'b1, 16'h0010, 16'h0010, "t6_ld");
      rst = 1'b1;
      tick();
      chk("t6_req", mem_req, 1'b0);
      chk("t6_pc", pc, 16'h0000);
      chk("t6_addr", mem_addr, 16'h0000);
      chk("t6_valid", instruction_valid, 1'b0);
      chk("t6_instr", instruction, 16'h0000);
      rst = 1'b0;
      tick();
      chk("t6_restart_req", mem_req, 1'b1);
      chk("t6_restart_addr", mem_addr, 16'h0000);

      // Ack on the last allowed FETCH cycle beats the timeout
      tick();
      tick();
      tick();
      chk("edge_req_c4", mem_req, 1'b1);
      chk("edge_err_c4", fetch_error, 1'b0);
      do_ack(16'h7777, "edge");
      chk("edge_err", fetch_error, 1'b0);

      // Test 5: timeout after 4 FETCH cycles
      do_exec(1'b0, 1'b0, 16'h0000, 16'h0000, "t5_ref");
      tick();
      tick();
      tick();
      chk("t5_err_c3", fetch_error, 1'b0);
      chk("t5_req_c3", mem_req, 1'b1);
      tick();
      chk("t5_err", fetch_error, 1'b1);
      chk("t5_req", mem_req, 1'b0);
      chk("t5_valid", instruction_valid, 1'b0);
      mem_ack = 1'b1;
      mem_rdata = 16'h9999;
      exec_done = 1'b1;
      tick();
      tick();
      mem_ack = 1'b0;
      mem_rdata = 16'h0000;
      exec_done = 1'b0;
      chk("t5_late_err", fetch_error, 1'b1);
      chk("t5_late_req", mem_req, 1'b0);
      chk("t5_late_valid", instruction_valid, 1'b0);
      chk("t5_late_instr", instruction, 16'h7777);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_err", fetch_error, 1'b0);
      tick();
      chk("t5_rst_req", mem_req, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
